// File: rtl/bomb_placement_controller.sv
// Fills an 8x8 board with distinct bomb positions drawn from an 8-bit LFSR,
// skipping repeats and the protected first-click cell.
//
// state  | meaning
// S_IDLE | waiting for start; outputs from the last run held
// S_DRAW | one LFSR candidate evaluated per cycle
// S_DONE | one-cycle completion pulse, then back to S_IDLE
module bomb_placement_controller #(
  parameter int          N_CELLS      = 64,
  parameter int          POS_W        = 6,
  parameter logic [7:0]  LFSR_DEFAULT = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [POS_W-1:0]   n_bombs_i,
  input  logic [7:0]         seed_i,
  input  logic               safe_en_i,
  input  logic [POS_W-1:0]   safe_pos_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pos_valid_o,
  output logic [POS_W-1:0]   pos_out_o,
  output logic [POS_W-1:0]   bomb_count_o,
  output logic [N_CELLS-1:0] bomb_map_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d, lfsr_next;
  logic [POS_W-1:0]   n_q, n_d;
  logic               safe_en_q, safe_en_d;
  logic [POS_W-1:0]   safe_pos_q, safe_pos_d;
  logic [N_CELLS-1:0] map_q, map_d;
  logic [POS_W-1:0]   count_q, count_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               pv_q, pv_d;

  logic [POS_W-1:0]   cand;
  logic [POS_W-1:0]   count_inc;
  logic               cand_taken;
  logic               cand_safe;
  logic               accept;

  // x^8+x^6+x^5+x^4+1; a nonzero seed keeps it off the all-zero lockup state
  assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand       = lfsr_next[POS_W-1:0];
  assign cand_taken = map_q[cand];
  assign cand_safe  = safe_en_q && (cand == safe_pos_q);
  assign accept     = (state_q == S_DRAW) && !cand_taken && !cand_safe;
  assign count_inc  = count_q + POS_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_DEFAULT;
      n_q        <= '0;
      safe_en_q  <= 1'b0;
      safe_pos_q <= '0;
      map_q      <= '0;
      count_q    <= '0;
      pos_q      <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      n_q        <= n_d;
      safe_en_q  <= safe_en_d;
      safe_pos_q <= safe_pos_d;
      map_q      <= map_d;
      count_q    <= count_d;
      pos_q      <= pos_d;
      pv_q       <= pv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    n_d        = n_q;
    safe_en_d  = safe_en_q;
    safe_pos_d = safe_pos_q;
    map_d      = map_q;
    count_d    = count_q;
    pos_d      = pos_q;
    pv_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d        = n_bombs_i;
          safe_en_d  = safe_en_i;
          safe_pos_d = safe_pos_i;
          lfsr_d     = (seed_i == 8'h00) ? LFSR_DEFAULT : seed_i;
          map_d      = '0;
          count_d    = '0;
          pos_d      = '0;
          state_d    = (n_bombs_i == '0) ? S_DONE : S_DRAW;
        end
      end
      S_DRAW: begin
        lfsr_d = lfsr_next;
        if (accept) begin
          map_d[cand] = 1'b1;
          count_d     = count_inc;
          pos_d       = cand;
          pv_d        = 1'b1;
          if (count_inc == n_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q == S_DRAW);
  assign done_o       = (state_q == S_DONE);
  assign pos_valid_o  = pv_q;
  assign pos_out_o    = pos_q;
  assign bomb_count_o = count_q;
  assign bomb_map_o   = map_q;

endmodule
